iob2axil: RTL and testbench

IOB2AXIL -- requirements
Module: iob2axil

---
 rtl/iob2axil_pkg.sv | 20 ++
 rtl/iob2axil.sv | 141 ++++++++++++++
 tb/tb_iob2axil.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob2axil_pkg.sv
// Shared definitions for the IOb to AXI-Lite bridge: FSM encoding and AXI response codes.
package iob2axil_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] AXI_PROT    = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/iob2axil.sv
// IOb native slave to AXI-Lite master bridge; one outstanding transaction, all outputs registered.
module iob2axil
  import iob2axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cke_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]          axil_awprot_o,
  output logic                axil_awvalid_o,
  input  logic                axil_awready_i,
  output logic [DATA_W-1:0]   axil_wdata_o,
  output logic [DATA_W/8-1:0] axil_wstrb_o,
  output logic                axil_wvalid_o,
  input  logic                axil_wready_i,
  input  logic [1:0]          axil_bresp_i,
  input  logic                axil_bvalid_i,
  output logic                axil_bready_o,
  output logic [ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]          axil_arprot_o,
  output logic                axil_arvalid_o,
  input  logic                axil_arready_i,
  input  logic [DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]          axil_rresp_i,
  input  logic                axil_rvalid_i,
  output logic                axil_rready_o
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [STRB_W-1:0]   req_wstrb;
  logic                aw_pending;
  logic                w_pending;

  // A channel stays pending until its own handshake; AW and W retire independently.
  assign aw_pending = axil_awvalid_o && !axil_awready_i;
  assign w_pending  = axil_wvalid_o && !axil_wready_i;

  assign axil_awaddr_o = req_addr;
  assign axil_araddr_o = req_addr;
  assign axil_awprot_o = AXI_PROT;
  assign axil_arprot_o = AXI_PROT;
  assign axil_wdata_o  = req_wdata;
  assign axil_wstrb_o  = req_wstrb;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      iob_ready_o    <= 1'b1;
      iob_rvalid_o   <= 1'b0;
      iob_rdata_o    <= '0;
      err_o          <= 1'b0;
      axil_awvalid_o <= 1'b0;
      axil_wvalid_o  <= 1'b0;
      axil_bready_o  <= 1'b0;
      axil_arvalid_o <= 1'b0;
      axil_rready_o  <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_wstrb      <= '0;
    end else if (cke_i) begin
      iob_rvalid_o <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (iob_avalid_i) begin
            req_addr    <= iob_addr_i;
            req_wdata   <= iob_wdata_i;
            req_wstrb   <= iob_wstrb_i;
            iob_ready_o <= 1'b0;
            if (|iob_wstrb_i) begin
              state          <= WRITE;
              axil_awvalid_o <= 1'b1;
              axil_wvalid_o  <= 1'b1;
            end else begin
              state          <= RADDR;
              axil_arvalid_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          axil_awvalid_o <= aw_pending;
          axil_wvalid_o  <= w_pending;
          if (!aw_pending && !w_pending) begin
            state         <= WRESP;
            axil_bready_o <= 1'b1;
          end
        end
        WRESP: begin
          if (axil_bvalid_i) begin
            state         <= IDLE;
            axil_bready_o <= 1'b0;
            iob_ready_o   <= 1'b1;
            err_o         <= resp_is_err(axil_bresp_i);
          end
        end
        RADDR: begin
          if (axil_arready_i) begin
            state          <= RDATA;
            axil_arvalid_o <= 1'b0;
            axil_rready_o  <= 1'b1;
          end
        end
        RDATA: begin
          if (axil_rvalid_i) begin
            state         <= IDLE;
            axil_rready_o <= 1'b0;
            iob_ready_o   <= 1'b1;
            iob_rdata_o   <= axil_rdata_i;
            iob_rvalid_o  <= 1'b1;
            err_o         <= resp_is_err(axil_rresp_i);
          end
        end
        default: begin
          state          <= IDLE;
          iob_ready_o    <= 1'b1;
          axil_awvalid_o <= 1'b0;
          axil_wvalid_o  <= 1'b0;
          axil_bready_o  <= 1'b0;
          axil_arvalid_o <= 1'b0;
          axil_rready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob2axil.sv
// Directed and randomized-stall bench for iob2axil with a 16-word AXI-Lite slave memory.
module tb_iob2axil;
  import iob2axil_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cke, iob_avalid;
  logic [31:0] iob_addr, iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready, iob_rvalid, err;
  logic [31:0] iob_rdata;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  iob2axil #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke),
    .iob_avalid_i(iob_avalid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
    .iob_wstrb_i(iob_wstrb), .iob_ready_o(iob_ready), .iob_rvalid_o(iob_rvalid),
    .iob_rdata_o(iob_rdata), .err_o(err),
    .axil_awaddr_o(awaddr), .axil_awprot_o(awprot), .axil_awvalid_o(awvalid),
    .axil_awready_i(awready), .axil_wdata_o(wdata), .axil_wstrb_o(wstrb),
    .axil_wvalid_o(wvalid), .axil_wready_i(wready), .axil_bresp_i(bresp),
    .axil_bvalid_i(bvalid), .axil_bready_o(bready), .axil_araddr_o(araddr),
    .axil_arprot_o(arprot), .axil_arvalid_o(arvalid), .axil_arready_i(arready),
    .axil_rdata_i(rdata), .axil_rresp_i(rresp), .axil_rvalid_i(rvalid),
    .axil_rready_o(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration, written only by the main sequence between transactions.
  int         aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [1:0] bresp_cfg, rresp_cfg;
  bit         slave_flush;

  // Slave-private state.
  logic [31:0] smem [16];
  bit          aw_done, w_done, b_done, ar_done, r_done, live;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  bit          pend_aw, pend_w, pend_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  int          stab_viol = 0;

  // Main-side state and per-transaction observations.
  logic [31:0] ref_mem [16];
  int          n_cyc, err_cnt, aw_cyc, w_cyc, b_hs, rv_cnt;
  logic [31:0] rd_data;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'hAABBCCDD;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: samples handshakes on pre-edge values, then drives its outputs 1 time unit after the edge.
  initial begin : slave
    for (int i = 0; i < 16; i++) smem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (pend_aw && (!awvalid || awaddr !== p_awaddr)) stab_viol++;
      if (pend_w && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) stab_viol++;
      if (pend_ar && (!arvalid || araddr !== p_araddr)) stab_viol++;
      live = rst_n && cke;
      if (live) begin
        if (awvalid && awready) begin aw_done = 1; s_awaddr = awaddr; end
        if (wvalid && wready) begin w_done = 1; s_wdata = wdata; s_wstrb = wstrb; end
        if (bvalid && bready) begin
          b_done = 1;
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) smem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
        end
        if (arvalid && arready) begin ar_done = 1; s_araddr = araddr; end
        if (rvalid && rready) r_done = 1;
      end
      pend_aw = rst_n && awvalid && !(awready && cke);
      pend_w  = rst_n && wvalid && !(wready && cke);
      pend_ar = rst_n && arvalid && !(arready && cke);
      p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb; p_araddr = araddr;
      #1;
      if (slave_flush || b_done) begin
        bvalid = 0; aw_done = 0; w_done = 0; b_done = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end
      if (slave_flush || r_done) begin
        rvalid = 0; ar_done = 0; r_done = 0; ar_cnt = 0; r_cnt = 0;
      end
      if (awvalid && !aw_done) begin awready = (aw_cnt >= aw_wait); aw_cnt++; end
      else awready = 0;
      if (wvalid && !w_done) begin wready = (w_cnt >= w_wait); w_cnt++; end
      else wready = 0;
      if (arvalid && !ar_done) begin arready = (ar_cnt >= ar_wait); ar_cnt++; end
      else arready = 0;
      if (aw_done && w_done && !bvalid) begin
        if (b_cnt >= b_wait) begin bvalid = 1; bresp = bresp_cfg; end
        else b_cnt++;
      end
      if (ar_done && !rvalid) begin
        if (r_cnt >= r_wait) begin rvalid = 1; rresp = rresp_cfg; rdata = smem[s_araddr[5:2]]; end
        else r_cnt++;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no completion by time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the negedge of the cycle after acceptance (cycle 1).
  task automatic iob_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output bit ok);
    ok = 0;
    iob_avalid = 1; iob_addr = a; iob_wdata = d; iob_wstrb = s;
    for (int i = 0; i < 100; i++) begin
      if (iob_ready && cke) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    iob_avalid = 0; iob_wstrb = 4'h0;
  endtask

  // Observes from cycle 1 until iob_rvalid (read) or iob_ready (write) is seen.
  task automatic wait_done(input bit is_read, input int budget, output bit ok);
    ok = 0; n_cyc = 0; err_cnt = 0; aw_cyc = 0; w_cyc = 0; b_hs = 0; rv_cnt = 0;
    for (int i = 1; i <= budget; i++) begin
      n_cyc = i;
      if (awvalid) aw_cyc++;
      if (wvalid) w_cyc++;
      if (bvalid && bready) b_hs++;
      if (iob_rvalid) rv_cnt++;
      if (err) err_cnt++;
      if (is_read ? iob_rvalid : iob_ready) begin ok = 1; rd_data = iob_rdata; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output bit ok);
    bit ok1, ok2;
    iob_req(a, d, s, ok1);
    wait_done(s == 4'h0, 100, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic ref_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  initial begin : main
    bit ok, late_bvalid, bready_seen, ready_low, rv_seen, arrdy_seen, err_exp, is_wr;
    int ar_hi, rr_hi, mism, done_cnt, idx;
    logic [31:0] d;
    logic [3:0]  s;

    rst_n = 0; cke = 1; iob_avalid = 0; iob_addr = 0; iob_wdata = 0; iob_wstrb = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY; slave_flush = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    check("rst_axi_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    check("rst_rvalid_err", 64'({iob_rvalid, err}), 64'(0));
    rst_n = 1;
    @(negedge clk);
    check("rst_ready", 64'(iob_ready), 64'(1));
    check("rst_rdata", 64'(iob_rdata), 64'(0));

    // Minimum-latency read.
    iob_req(32'h0000_0010, 32'h0, 4'h0, ok);
    check("rd_arvalid_c1", 64'(arvalid), 64'(1));
    check("rd_araddr", 64'(araddr), 64'h10);
    check("rd_arprot", 64'(arprot), 64'(0));
    wait_done(1, 50, ok);
    check("rd_done", 64'(ok), 64'(1));
    check("rd_latency", 64'(n_cyc), 64'(3));
    check("rd_data", 64'(rd_data), 64'hDEADBEEF);
    check("rd_err", 64'(err_cnt), 64'(0));
    check("ready_during_rvalid", 64'(iob_ready), 64'(1));

    // Back-to-back write with a delayed awready.
    aw_wait = 2;
    iob_req(32'h0000_0020, 32'h1234_5678, 4'b0011, ok);
    check("wr_awaddr", 64'(awaddr), 64'h20);
    check("wr_wdata_wstrb", 64'({wdata, wstrb}), 64'({32'h1234_5678, 4'b0011}));
    check("wr_awprot", 64'(awprot), 64'(0));
    wait_done(0, 50, ok);
    ref_write(8, 32'h1234_5678, 4'b0011);
    check("wr_done", 64'(ok), 64'(1));
    check("wr_awvalid_cycles", 64'(aw_cyc), 64'(3));
    check("wr_wvalid_cycles", 64'(w_cyc), 64'(1));
    check("wr_b_handshakes", 64'(b_hs), 64'(1));
    check("wr_no_rvalid", 64'(rv_cnt), 64'(0));
    check("wr_latency", 64'(n_cyc), 64'(5));
    check("rdata_hold", 64'(iob_rdata), 64'hDEADBEEF);
    aw_wait = 0;

    // Minimum-latency write.
    do_txn(32'h0000_0024, 32'hCAFE_F00D, 4'hF, ok);
    ref_write(9, 32'hCAFE_F00D, 4'hF);
    check("wr_min_latency", 64'(n_cyc), 64'(3));
    check("wr_min_err", 64'(err_cnt), 64'(0));

    do_txn(32'h0000_0020, 32'h0, 4'h0, ok);
    check("rd_back_partial", 64'(rd_data), 64'hAABB_5678);

    // SLVERR read and write.
    rresp_cfg = RESP_SLVERR;
    do_txn(32'h0000_0024, 32'h0, 4'h0, ok);
    check("slverr_rd_data", 64'(rd_data), 64'hCAFE_F00D);
    check("slverr_rd_err_with_rvalid", 64'({err, iob_rvalid}), 64'(2'b11));
    @(negedge clk);
    check("slverr_rd_pulse_len", 64'({err, iob_rvalid}), 64'(0));
    rresp_cfg = RESP_OKAY;
    bresp_cfg = RESP_SLVERR;
    do_txn(32'h0000_002C, 32'h55AA_55AA, 4'b1000, ok);
    ref_write(11, 32'h55AA_55AA, 4'b1000);
    check("slverr_wr_err", 64'(err_cnt), 64'(1));
    check("slverr_wr_no_rvalid", 64'(rv_cnt), 64'(0));
    bresp_cfg = RESP_OKAY;
    do_txn(32'h0000_002C, 32'h0, 4'h0, ok);
    check("rd_back_msb", 64'(rd_data), 64'h550B_0B0B);

    // Reset while waiting in WRESP, then a late bvalid.
    b_wait = 30;
    iob_req(32'h0000_0028, 32'h1111_2222, 4'hF, ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("wresp_reached", 64'(ok), 64'(1));
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_mid_bready", 64'(bready), 64'(0));
    rst_n = 1;
    late_bvalid = 0; bready_seen = 0; ready_low = 0; rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bvalid) late_bvalid = 1;
      if (bready) bready_seen = 1;
      if (!iob_ready) ready_low = 1;
      if (iob_rvalid || err) rv_seen = 1;
    end
    check("late_bvalid_seen", 64'(late_bvalid), 64'(1));
    check("late_bready_stays_0", 64'(bready_seen), 64'(0));
    check("late_ready_stays_1", 64'(ready_low), 64'(0));
    check("late_no_rvalid_err", 64'(rv_seen), 64'(0));
    check("rst_mid_rdata", 64'(iob_rdata), 64'(0));
    slave_flush = 1;
    @(negedge clk);
    slave_flush = 0;
    b_wait = 0;
    @(negedge clk);

    // Clock enable held low with arready asserted.
    iob_req(32'h0000_0010, 32'h0, 4'h0, ok);
    check("cke_arvalid_c1", 64'(arvalid), 64'(1));
    cke = 0;
    ar_hi = 0; rr_hi = 0; arrdy_seen = 0; rv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (arvalid) ar_hi++;
      if (arready) arrdy_seen = 1;
      if (rready) rr_hi++;
      if (iob_rvalid || iob_ready) rv_seen = 1;
    end
    check("cke_arvalid_held", 64'(ar_hi), 64'(5));
    check("cke_arready_offered", 64'(arrdy_seen), 64'(1));
    check("cke_no_rready", 64'(rr_hi), 64'(0));
    check("cke_iob_frozen", 64'(rv_seen), 64'(0));
    cke = 1;
    wait_done(1, 50, ok);
    check("cke_rd_latency", 64'(n_cyc), 64'(3));
    check("cke_rd_data", 64'(rd_data), 64'hDEADBEEF);

    // Read, write, read triplets with random stalls and random error responses.
    mism = 0; done_cnt = 0;
    for (int it = 0; it < 1000; it++) begin
      for (int k = 0; k < 3; k++) begin
        is_wr = (k == 1);
        idx = int'($urandom_range(0, 15));
        aw_wait = int'($urandom_range(0, 2)); w_wait = int'($urandom_range(0, 2));
        b_wait = int'($urandom_range(0, 2)); ar_wait = int'($urandom_range(0, 2));
        r_wait = int'($urandom_range(0, 2));
        err_exp = ($urandom_range(0, 3) == 0);
        if (is_wr) begin
          bresp_cfg = err_exp ? RESP_SLVERR : RESP_OKAY;
          d = $urandom;
          s = 4'($urandom_range(1, 15));
          do_txn(32'(idx) << 2, d, s, ok);
          ref_write(idx, d, s);
          if (!ok || b_hs != 1 || rv_cnt != 0 || err_cnt != (err_exp ? 1 : 0)) mism++;
        end else begin
          rresp_cfg = err_exp ? RESP_SLVERR : RESP_OKAY;
          do_txn(32'(idx) << 2, 32'h0, 4'h0, ok);
          if (!ok || rd_data !== ref_mem[idx] || err_cnt != (err_exp ? 1 : 0)) mism++;
        end
        if (ok) done_cnt++;
      end
    end
    check("rand_scoreboard", 64'(mism), 64'(0));
    check("rand_completed", 64'(done_cnt), 64'(3000));
    check("axi_stability", 64'(stab_viol), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
